// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package fetch_pkg;

    localparam int          FETCH_BUF_DEPTH = 4;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf_ctrl.sv
// Pointer/count bookkeeping and push/pop/flush qualification for the fetch buffer.
// Optional zero-latency bypass of an empty buffer when FETCH_BUF_BYPASS_EN is defined.
module fetch_buf_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_valid,
    input  logic                       pop_ready,
    output logic                       push_ready,
    output logic                       pop_valid,
    output logic                       bypass,
    output logic                       wr_en,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic empty;
    logic pop_fire;

    always_comb begin
        empty      = (count == '0);
        push_ready = (count != FULL_COUNT);
        pop_fire   = !empty && pop_ready && !flush;
`ifdef FETCH_BUF_BYPASS_EN
        // An empty buffer forwards the incoming word; it is stored only if decode stalls.
        bypass     = empty && push_valid && !flush;
        pop_valid  = !empty || bypass;
        wr_en      = push_valid && push_ready && !flush && !(bypass && pop_ready);
`else
        bypass     = 1'b0;
        pop_valid  = !empty;
        wr_en      = push_valid && push_ready && !flush;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop_fire)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(wr_en) - CW'(pop_fire);
        end
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Prefetch queue between instruction memory and decode: storage array and head output mux.
// Build option FETCH_BUF_BYPASS_EN enables same-cycle forwarding when the buffer is empty.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     push_valid_i,
    input  logic [31:0]              push_instr_i,
    input  logic [31:0]              push_pc_i,
    output logic                     push_ready_o,
    input  logic                     pop_ready_i,
    output logic                     pop_valid_o,
    output logic [31:0]              instr_d_o,
    output logic [31:0]              pc_d_o,
    output logic [31:0]              pc_plus4_d_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    fetch_entry_t     head;
    logic             bypass;
    logic             wr_en;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    fetch_buf_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk        (clk_i),
        .rst        (reset_i),
        .flush      (flush_i),
        .push_valid (push_valid_i),
        .pop_ready  (pop_ready_i),
        .push_ready (push_ready_o),
        .pop_valid  (pop_valid_o),
        .bypass     (bypass),
        .wr_en      (wr_en),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .count      (count_o)
    );

    // Storage holds data only; validity lives entirely in the control counters.
    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_ptr] <= '{instr: push_instr_i, pc: push_pc_i};
    end

    always_comb begin
        head = bypass ? fetch_entry_t'{instr: push_instr_i, pc: push_pc_i} : mem[rd_ptr];
        if (pop_valid_o) begin
            instr_d_o = head.instr;
            pc_d_o    = head.pc;
        end else begin
            instr_d_o = NOP_INSTR;
            pc_d_o    = 32'h0;
        end
        pc_plus4_d_o = pc_d_o + 32'd4;
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: vector table, corner sequences, randomized run vs queue model.
module tb_instr_fetch_buffer;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        push_valid_i;
    logic [31:0] push_instr_i;
    logic [31:0] push_pc_i;
    logic        push_ready_o;
    logic        pop_ready_i;
    logic        pop_valid_o;
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pc_plus4_d_o;
    logic [$clog2(DEPTH):0] count_o;

    int checks = 0;
    int errors = 0;
    fetch_entry_t q[$];

    instr_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .push_valid_i (push_valid_i),
        .push_instr_i (push_instr_i),
        .push_pc_i    (push_pc_i),
        .push_ready_o (push_ready_o),
        .pop_ready_i  (pop_ready_i),
        .pop_valid_o  (pop_valid_o),
        .instr_d_o    (instr_d_o),
        .pc_d_o       (pc_d_o),
        .pc_plus4_d_o (pc_plus4_d_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        pv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pr;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        int          ec;
        logic        erdy;
    } vec_t;

    function automatic vec_t mk(logic f, logic pv, logic [31:0] ins, logic [31:0] pc, logic pr,
                                logic ev, logic [31:0] ei, logic [31:0] ep, int ec, logic erdy);
        vec_t v;
        v.flush = f; v.pv = pv; v.instr = ins; v.pc = pc; v.pr = pr;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.erdy = erdy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic apply(input logic f, input logic pv, input logic [31:0] ins,
                         input logic [31:0] pc, input logic pr);
        @(negedge clk);
        flush_i = f; push_valid_i = pv; push_instr_i = ins; push_pc_i = pc; pop_ready_i = pr;
        #1;
    endtask

    task automatic check_outputs(input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                                 input int ec, input logic erdy);
        check("pop_valid", 32'(pop_valid_o), 32'(ev));
        check("instr", instr_d_o, ei);
        check("pc", pc_d_o, ep);
        check("pc_plus4", pc_plus4_d_o, ep + 32'd4);
        check("count", 32'(count_o), 32'(ec));
        check("push_ready", 32'(push_ready_o), 32'(erdy));
    endtask

    // One cycle against the queue model: expected outputs come from queue contents and inputs.
    task automatic step(input logic f, input logic pv, input logic [31:0] ins,
                        input logic [31:0] pc, input logic pr);
        int           n;
        logic         byp;
        logic         ev;
        logic         erdy;
        fetch_entry_t head;
        apply(f, pv, ins, pc, pr);
        n = q.size();
        byp = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
        byp = (n == 0) && pv && !f;
`endif
        ev   = (n != 0) || byp;
        erdy = (n != DEPTH);
        if (byp)         head = '{instr: ins, pc: pc};
        else if (n != 0) head = q[0];
        else             head = '{instr: NOP_INSTR, pc: 32'h0};
        check_outputs(ev, head.instr, head.pc, n, erdy);
        @(posedge clk);
        if (f) begin
            q.delete();
        end else if (!(byp && pr)) begin
            if (ev && pr) void'(q.pop_front());
            if (pv && erdy) q.push_back('{instr: ins, pc: pc});
        end
    endtask

    vec_t tbl[22];

    initial begin
        tbl[0]  = mk(0,1,32'h00500093,32'h100,0, 0,NOP_INSTR,32'h0,0,1);
        tbl[1]  = mk(0,1,32'h00A00113,32'h104,0, 1,32'h00500093,32'h100,1,1);
        tbl[2]  = mk(0,0,32'h0,32'h0,0,          1,32'h00500093,32'h100,2,1);
        tbl[3]  = mk(0,0,32'h0,32'h0,1,          1,32'h00500093,32'h100,2,1);
        tbl[4]  = mk(0,0,32'h0,32'h0,1,          1,32'h00A00113,32'h104,1,1);
        tbl[5]  = mk(0,0,32'h0,32'h0,1,          0,NOP_INSTR,32'h0,0,1);
        tbl[6]  = mk(0,1,32'hA000_0000,32'h200,0, 0,NOP_INSTR,32'h0,0,1);
        tbl[7]  = mk(0,1,32'hA000_0001,32'h204,0, 1,32'hA000_0000,32'h200,1,1);
        tbl[8]  = mk(0,1,32'hA000_0002,32'h208,0, 1,32'hA000_0000,32'h200,2,1);
        tbl[9]  = mk(0,1,32'hA000_0003,32'h20C,0, 1,32'hA000_0000,32'h200,3,1);
        tbl[10] = mk(0,1,32'hA000_0004,32'h210,1, 1,32'hA000_0000,32'h200,4,0);
        tbl[11] = mk(0,0,32'h0,32'h0,1,          1,32'hA000_0001,32'h204,3,1);
        tbl[12] = mk(0,0,32'h0,32'h0,1,          1,32'hA000_0002,32'h208,2,1);
        tbl[13] = mk(0,0,32'h0,32'h0,1,          1,32'hA000_0003,32'h20C,1,1);
        tbl[14] = mk(0,1,32'hB000_0000,32'h300,0, 0,NOP_INSTR,32'h0,0,1);
        tbl[15] = mk(0,1,32'hB000_0001,32'h304,0, 1,32'hB000_0000,32'h300,1,1);
        tbl[16] = mk(0,1,32'hB000_0002,32'h308,0, 1,32'hB000_0000,32'h300,2,1);
        tbl[17] = mk(1,1,32'hB000_0003,32'h30C,1, 1,32'hB000_0000,32'h300,3,1);
        tbl[18] = mk(0,0,32'h0,32'h0,1,          0,NOP_INSTR,32'h0,0,1);
        tbl[19] = mk(0,1,32'hC000_0000,32'h400,0, 0,NOP_INSTR,32'h0,0,1);
        tbl[20] = mk(0,0,32'h0,32'h0,1,          1,32'hC000_0000,32'h400,1,1);
        tbl[21] = mk(0,0,32'h0,32'h0,0,          0,NOP_INSTR,32'h0,0,1);

        reset_i = 1'b1; flush_i = 1'b0; push_valid_i = 1'b0;
        push_instr_i = 32'h0; push_pc_i = 32'h0; pop_ready_i = 1'b0;
        #2;
        check_outputs(1'b0, NOP_INSTR, 32'h0, 0, 1'b1);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        step(0, 0, 32'h0, 32'h0, 0);

        for (int i = 0; i < 22; i++) begin
`ifdef FETCH_BUF_BYPASS_EN
            step(tbl[i].flush, tbl[i].pv, tbl[i].instr, tbl[i].pc, tbl[i].pr);
`else
            apply(tbl[i].flush, tbl[i].pv, tbl[i].instr, tbl[i].pc, tbl[i].pr);
            check_outputs(tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].ec, tbl[i].erdy);
            @(posedge clk);
`endif
        end

        // Empty-buffer latency, PC wrap on pc_plus4.
        apply(0, 1, 32'hFFF00193, 32'hFFFF_FFFC, 1);
`ifdef FETCH_BUF_BYPASS_EN
        check("byp_valid", 32'(pop_valid_o), 32'h1);
        check("byp_instr", instr_d_o, 32'hFFF00193);
        check("byp_pc4", pc_plus4_d_o, 32'h0);
        check("byp_count", 32'(count_o), 32'h0);
        @(posedge clk);
        apply(0, 0, 32'h0, 32'h0, 0);
        check("byp_count_after", 32'(count_o), 32'h0);
        check("byp_valid_after", 32'(pop_valid_o), 32'h0);
        @(posedge clk);
`else
        check("lat_valid0", 32'(pop_valid_o), 32'h0);
        @(posedge clk);
        apply(0, 0, 32'h0, 32'h0, 1);
        check("lat_valid1", 32'(pop_valid_o), 32'h1);
        check("lat_instr", instr_d_o, 32'hFFF00193);
        check("lat_pc4", pc_plus4_d_o, 32'h0);
        check("lat_count", 32'(count_o), 32'h1);
        @(posedge clk);
        apply(0, 0, 32'h0, 32'h0, 0);
        check("lat_drained", 32'(count_o), 32'h0);
        @(posedge clk);
`endif

        // Continuous push/pop across pointer wrap.
        step(0, 1, 32'hD000_0000, 32'h500, 0);
        step(0, 1, 32'hD000_0001, 32'h504, 0);
        for (int i = 2; i < 12; i++)
            step(0, 1, 32'hD000_0000 + 32'(i), 32'h500 + 32'(4 * i), 1);
        for (int i = 0; i < 4; i++)
            step(0, 0, 32'h0, 32'h0, 1);

        // Reset asserted between clock edges while holding entries.
        for (int i = 0; i < 3; i++)
            step(0, 1, 32'hE000_0000 + 32'(i), 32'h600 + 32'(4 * i), 0);
        #1;
        push_valid_i = 1'b0; pop_ready_i = 1'b0;
        #1 reset_i = 1'b1;
        #1;
        check_outputs(1'b0, NOP_INSTR, 32'h0, 0, 1'b1);
        @(negedge clk);
        reset_i = 1'b0;
        q.delete();
        step(0, 0, 32'h0, 32'h0, 1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            logic        f, pv, pr;
            logic [31:0] ins, pc;
            f   = ($urandom_range(0, 99) < 5);
            pv  = ($urandom_range(0, 99) < 70);
            pr  = ($urandom_range(0, 99) < 55);
            ins = $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            step(f, pv, ins, pc, pr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
